dmux_dispatch: RTL and testbench

- Upstream feeder for the 32-bit 1-to-4 word demultiplexer.
- Accepts tagged words over a valid/ready handshake and buffers them in a small FIFO.
- Presents one word at a time on a registered din/sel pair to the demux, stalling until the addressed channel is ready.
- Optional round-robin mode ignores input tags and distributes words cyclically over channels 0..3.

---
 rtl/dmux_dispatch_if.sv | 27 ++
 rtl/dmux_dispatch.sv | 86 ++++++++
 tb/tb_dmux_dispatch.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmux_dispatch_if.sv
// Handshake bundle between the word source, the dispatcher and the 1-to-4 demux.
// The dispatcher uses the slave view; the word source/consumer side uses the master view.
interface dmux_dispatch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic              in_valid;
  logic              in_ready;
  logic              rr_mode;
  logic [3:0]        ch_ready;
  logic [DATA_W-1:0] dout;
  logic [1:0]        sel;
  logic              dout_valid;
  logic [ADDR_W:0]   count;

  modport slave (
    input  in_data, in_dest, in_valid, rr_mode, ch_ready,
    output in_ready, dout, sel, dout_valid, count
  );

  modport master (
    output in_data, in_dest, in_valid, rr_mode, ch_ready,
    input  in_ready, dout, sel, dout_valid, count
  );
endinterface

// File: rtl/dmux_dispatch.sv
// Buffers tagged words in a small FIFO and presents them one at a time on a
// registered din/sel pair, stalling until the addressed demux channel is ready.
module dmux_dispatch #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmux_dispatch_if.slave  bus
);
  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W+1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        rr_q, sel_q;
  logic [DATA_W-1:0] dout_q;
  state_t            state_q;

  logic              push, pop, accept;
  logic [DATA_W+1:0] head;

  assign bus.in_ready = (count_q != FULL_CNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign accept       = (state_q == HOLD) && bus.ch_ready[sel_q];
  // The output register refills whenever it is empty or being drained this edge.
  assign pop          = (count_q != '0) && ((state_q == IDLE) || accept);
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_dest, bus.in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 2'd0;
      sel_q    <= 2'd0;
      dout_q   <= '0;
      state_q  <= IDLE;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        dout_q   <= head[DATA_W-1:0];
        state_q  <= HOLD;
        if (bus.rr_mode) begin
          sel_q <= rr_q;
          rr_q  <= rr_q + 2'd1;
        end else begin
          sel_q <= head[DATA_W+1:DATA_W];
        end
      end else if (accept) begin
        // sel keeps its last value so the demux select does not glitch when idle.
        dout_q  <= '0;
        state_q <= IDLE;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.sel        = sel_q;
  assign bus.dout_valid = (state_q == HOLD);
  assign bus.count      = count_q;
endmodule

// File: tb/tb_dmux_dispatch.sv
// Scoreboard bench for dmux_dispatch: stimulus queues expected {sel,data}, a
// negedge monitor pops and compares every word the demux side accepts.
module tb_dmux_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmux_dispatch_if #(.DATA_W(32), .ADDR_W(2)) bus();

  dmux_dispatch #(.DATA_W(32), .DEPTH(4), .ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  int          sel_log[$];
  int          model_rr = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: words leave in push order; channel is the tag, or a free-running
  // 0,1,2,3 count of round-robin words.
  task automatic expect_word(input logic [31:0] d, input logic [1:0] dest);
    logic [1:0] s;
    if (bus.rr_mode) begin
      s = 2'(model_rr % 4);
      model_rr++;
    end else begin
      s = dest;
    end
    exp_q.push_back({s, d});
  endtask

  task automatic push_word(input logic [31:0] d, input logic [1:0] dest);
    int n = 0;
    bus.in_data  = d;
    bus.in_dest  = dest;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("push_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    expect_word(d, dest);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.ch_ready = 4'hF;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_idle", 64'(bus.dout_valid), 64'd0);
    chk("drain_count", 64'(bus.count), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dout_valid) begin
        if (bus.ch_ready[bus.sel]) begin
          tests++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_out: got sel=%0d data=%h, expected no word", bus.sel, bus.dout);
          end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if ({bus.sel, bus.dout} !== e) begin
              errors++;
              $display("[TB] FAIL out_word: got sel=%0d data=%h, expected sel=%0d data=%h",
                       bus.sel, bus.dout, e[33:32], e[31:0]);
            end else begin
              $display("[TB] out sel=%0d data=%h", bus.sel, bus.dout);
            end
          end
          sel_log.push_back(int'(bus.sel));
        end
      end else begin
        tests++;
        if (bus.dout !== 32'd0) begin
          errors++;
          $display("[TB] FAIL idle_dout: got %h, expected 0", bus.dout);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [31:0] frz_d;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    bus.in_data  = '0;
    bus.in_dest  = 2'd0;
    bus.in_valid = 1'b0;
    bus.rr_mode  = 1'b0;
    bus.ch_ready = 4'hF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_valid", 64'(bus.dout_valid), 64'd0);
    chk("rst_sel", 64'(bus.sel), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word, latency of one edge after the push edge
    push_word(32'hA5A5A5A5, 2'd2);
    chk("no_bypass", 64'(bus.dout_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_valid", 64'(bus.dout_valid), 64'd1);
    chk("t1_dout", 64'(bus.dout), 64'hA5A5A5A5);
    chk("t1_sel", 64'(bus.sel), 64'd2);
    @(posedge clk); #1;
    chk("t1_idle_valid", 64'(bus.dout_valid), 64'd0);
    chk("t1_idle_dout", 64'(bus.dout), 64'd0);
    chk("t1_sel_hold", 64'(bus.sel), 64'd2);

    // Fill with consumers stalled, then full-while-popping
    bus.ch_ready = 4'h0;
    for (int i = 0; i < 4; i++) push_word($urandom, 2'(i));
    chk("t2_count3", 64'(bus.count), 64'd3);
    chk("t2_valid", 64'(bus.dout_valid), 64'd1);
    push_word(32'h5555_0005, 2'd1);
    chk("t2_count4", 64'(bus.count), 64'd4);
    chk("t2_full", 64'(bus.in_ready), 64'd0);
    bus.in_data  = 32'h6666_0006;
    bus.in_dest  = 2'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("t2_no_push_full", 64'(bus.count), 64'd4);
    bus.ch_ready = 4'hF;
    @(posedge clk); #1;
    chk("t5_count_drop", 64'(bus.count), 64'd3);
    chk("t5_in_ready", 64'(bus.in_ready), 64'd1);
    expect_word(bus.in_data, bus.in_dest);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t5_push_pop", 64'(bus.count), 64'd3);
    drain();

    // Round-robin ignores tags
    bus.rr_mode = 1'b1;
    sel_log.delete();
    for (int i = 0; i < 6; i++) push_word($urandom, 2'd3);
    drain();
    chk("t3_rr_len", 64'(sel_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < sel_log.size(); i++)
      chk($sformatf("t3_rr_sel%0d", i), 64'(sel_log[i]), 64'(rr_exp[i]));
    bus.rr_mode = 1'b0;

    // Stall on the addressed channel only
    bus.ch_ready = 4'b1101;
    push_word(32'hC0DE_0001, 2'd1);
    @(posedge clk); #1;
    chk("t4_valid", 64'(bus.dout_valid), 64'd1);
    frz_d = bus.dout;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_frz_dout", 64'(bus.dout), 64'(frz_d));
      chk("t4_frz_sel", 64'(bus.sel), 64'd1);
      chk("t4_frz_valid", 64'(bus.dout_valid), 64'd1);
    end
    bus.ch_ready = 4'hF;
    @(posedge clk); #1;
    chk("t4_release", 64'(bus.dout_valid), 64'd0);
    drain();

    // Randomised traffic in both selection modes
    for (int ph = 0; ph < 2; ph++) begin
      bus.rr_mode = ph[0];
      for (int c = 0; c < 250; c++) begin
        bus.ch_ready = 4'($urandom_range(0, 15));
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = $urandom;
        bus.in_dest  = 2'($urandom_range(0, 3));
        if (bus.in_valid && bus.in_ready) expect_word(bus.in_data, bus.in_dest);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      drain();
    end

    // Asynchronous reset mid-stream
    bus.rr_mode  = 1'b0;
    bus.ch_ready = 4'h0;
    for (int i = 0; i < 4; i++) push_word($urandom, 2'(i));
    chk("t6_pre_count", 64'(bus.count), 64'd3);
    chk("t6_pre_valid", 64'(bus.dout_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_dout", 64'(bus.dout), 64'd0);
    chk("t6_valid", 64'(bus.dout_valid), 64'd0);
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    model_rr = 0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Round-robin pointer restarts at channel 0 after reset
    bus.rr_mode  = 1'b1;
    bus.ch_ready = 4'hF;
    sel_log.delete();
    push_word(32'h1234_5678, 2'd3);
    drain();
    chk("t6_rr_restart", 64'(sel_log.size() > 0 ? sel_log[0] : 9), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
